fetch_stage: RTL



---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_stage_pkt_reg.sv | 38 +++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage types and constants
package fetch_stage_pkg;

   localparam int INSN_BYTES = 4;

   // Packet mask field is sized for the widest supported lane mask;
   // the top zero-extends its EXEC_MASK_W mask into it.
   localparam int PKT_MASK_W = 32;

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT_RSP,
      S_PUSH,
      S_DRAIN,
      S_HALTED
   } fetch_state_t;

   typedef struct packed {
      logic [PKT_MASK_W-1:0] exec_mask;
      logic [63:0]           pc;
      logic [31:0]           insn;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - imem, decode, redirect and halt signals of the fetch stage
interface fetch_stage_if #(
   parameter int EXEC_MASK_W = 4
);
   logic                   imem_req_valid;
   logic [63:0]            imem_req_addr;
   logic                   imem_req_ready;
   logic                   imem_rsp_valid;
   logic [31:0]            imem_rsp_data;
   logic                   dec_valid;
   logic [63:0]            dec_pc;
   logic [31:0]            dec_insn;
   logic [EXEC_MASK_W-1:0] dec_exec_mask;
   logic                   dec_ready;
   logic                   redir_valid;
   logic [63:0]            redir_pc;
   logic [EXEC_MASK_W-1:0] redir_mask;
   logic                   halt;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output dec_valid, dec_pc, dec_insn, dec_exec_mask,
      input  dec_ready, redir_valid, redir_pc, redir_mask, halt
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  dec_valid, dec_pc, dec_insn, dec_exec_mask,
      output dec_ready, redir_valid, redir_pc, redir_mask, halt
   );
endinterface

// File: rtl/fetch_stage_pkt_reg.sv
// rtl/fetch_stage_pkt_reg.sv - valid/ready holding register for the fetch-to-decode packet
module fetch_pkt_reg
   import fetch_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic       i_clear,
   input  logic       i_ready,
   input  fetch_pkt_t i_pkt,
   output logic       o_valid,
   output fetch_pkt_t o_pkt
);

   logic       r_valid;
   fetch_pkt_t r_pkt;

   // Hold the packet stable until decode takes it; a clear (redirect/halt) discards it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid         <= 1'b0;
         r_pkt.exec_mask <= '1;
         r_pkt.pc        <= '0;
         r_pkt.insn      <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pkt   <= i_pkt;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_pkt   = r_pkt;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM; define FETCH_STAGE_TRACE_EN for a per-packet trace
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int          CORE_ID     = 0,
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          EXEC_MASK_W = 4
) (
   input logic           clk,
   input logic           rst_n,
   fetch_stage_if.master bus
);

   localparam int lp_unused_core_id = CORE_ID;

   fetch_state_t           r_state;
   fetch_state_t           w_next_state;
   logic [63:0]            r_pc;
   logic [63:0]            w_next_pc;
   logic [EXEC_MASK_W-1:0] r_mask;
   logic [EXEC_MASK_W-1:0] w_next_mask;
   logic                   r_req_valid;
   logic                   r_halt_pend;
   logic                   w_req_fire;
   logic                   w_halt_seen;
   logic                   w_load;
   logic                   w_clear;
   logic                   w_dec_valid;
   fetch_pkt_t             w_pkt_in;
   fetch_pkt_t             w_pkt_out;
   logic                   w_unused_mask_hi;

   assign w_req_fire  = r_req_valid && bus.imem_req_ready;
   assign w_halt_seen = r_halt_pend || bus.halt;

   // Next state, next PC/mask and packet load/clear; halt beats redirect beats accept.
   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_next_mask  = r_mask;
      w_load       = 1'b0;
      w_clear      = 1'b0;
      case (r_state)
         S_REQ: begin
            // A request taken this cycle leaves a response in flight, so drain it first.
            if (bus.halt) begin
               w_next_state = w_req_fire ? S_DRAIN : S_HALTED;
            end else if (bus.redir_valid) begin
               w_next_pc    = bus.redir_pc;
               w_next_mask  = bus.redir_mask;
               w_next_state = w_req_fire ? S_DRAIN : S_REQ;
            end else if (w_req_fire) begin
               w_next_state = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            // A response arriving with the halt/redirect is the outstanding one: drop it here.
            if (bus.halt) begin
               w_next_state = bus.imem_rsp_valid ? S_HALTED : S_DRAIN;
            end else if (bus.redir_valid) begin
               w_next_pc    = bus.redir_pc;
               w_next_mask  = bus.redir_mask;
               w_next_state = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
            end else if (bus.imem_rsp_valid) begin
               w_load       = 1'b1;
               w_next_state = S_PUSH;
            end
         end
         S_PUSH: begin
            if (bus.halt) begin
               w_clear      = 1'b1;
               w_next_state = S_HALTED;
            end else if (bus.redir_valid) begin
               w_clear      = 1'b1;
               w_next_pc    = bus.redir_pc;
               w_next_mask  = bus.redir_mask;
               w_next_state = S_REQ;
            end else if (bus.dec_ready) begin
               w_next_pc    = r_pc + 64'(INSN_BYTES);
               w_next_state = S_REQ;
            end
         end
         S_DRAIN: begin
            if (bus.redir_valid && !w_halt_seen) begin
               w_next_pc   = bus.redir_pc;
               w_next_mask = bus.redir_mask;
            end
            if (bus.imem_rsp_valid) begin
               w_next_state = w_halt_seen ? S_HALTED : S_REQ;
            end
         end
         S_HALTED: begin
            w_next_state = S_HALTED;
         end
         default: begin
            w_next_state = S_REQ;
         end
      endcase
   end

   // State, PC, mask, sticky halt and registered request-valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_mask      <= '1;
         r_req_valid <= 1'b0;
         r_halt_pend <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_pc        <= w_next_pc;
         r_mask      <= w_next_mask;
         r_req_valid <= (w_next_state == S_REQ);
         r_halt_pend <= w_halt_seen;
      end
   end

   assign w_pkt_in.exec_mask = PKT_MASK_W'(r_mask);
   assign w_pkt_in.pc        = r_pc;
   assign w_pkt_in.insn      = bus.imem_rsp_data;

   fetch_pkt_reg u_pkt_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_clear (w_clear),
      .i_ready (bus.dec_ready),
      .i_pkt   (w_pkt_in),
      .o_valid (w_dec_valid),
      .o_pkt   (w_pkt_out)
   );

   assign w_unused_mask_hi = ^w_pkt_out.exec_mask;

   assign bus.imem_req_valid = r_req_valid;
   assign bus.imem_req_addr  = r_pc;
   assign bus.dec_valid      = w_dec_valid;
   assign bus.dec_pc         = w_pkt_out.pc;
   assign bus.dec_insn       = w_pkt_out.insn;
   assign bus.dec_exec_mask  = w_pkt_out.exec_mask[EXEC_MASK_W-1:0];

`ifdef FETCH_STAGE_TRACE_EN
   // Trace each packet on the cycle decode accepts it.
   always_ff @(posedge clk) begin
      if (rst_n && w_dec_valid && bus.dec_ready) begin
         $display("FETCH[%0d] send: %h %h", lp_unused_core_id, w_pkt_out.pc, w_pkt_out.insn);
      end
   end
`else
`endif

endmodule
